pc_queue_mc: RTL and testbench

PC_QUEUE_MC -- requirements
Module: pc_queue_mc

---
 rtl/pc_queue_mc_pkg.sv | 11 +
 rtl/pc_fifo.sv | 79 +++++++
 rtl/pc_queue_mc.sv | 118 +++++++++++
 tb/tb_pc_queue_mc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_queue_mc_pkg.sv
// rtl/pc_queue_mc_pkg.sv - shared packet width and derived-width helper for the packet queue
package pc_queue_mc_pkg;

    localparam int PC_PACKET_WIDTH = 175;

    // A single channel still needs a one-bit channel field.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pc_fifo.sv
// rtl/pc_fifo.sv - single-channel packet FIFO with combinational head and occupancy count
module pc_fifo
    import pc_queue_mc_pkg::*;
#(
    parameter int PACKET_WIDTH = PC_PACKET_WIDTH,
    parameter int DEPTH        = 16,
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [PACKET_WIDTH-1:0] wr_data,
    input  logic                    rd_en,
    output logic                    full,
    output logic                    empty,
    output logic [CNT_W-1:0]        count,
    output logic [PACKET_WIDTH-1:0] head
);

    logic [PACKET_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    wr_ok;
    logic                    rd_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rd_ptr_q];

    assign wr_ok = wr_en && !full && !flush;
    assign rd_ok = rd_en && !empty && !flush;

    // Storage is deliberately left out of reset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pc_queue_mc.sv
// rtl/pc_queue_mc.sv - multi-channel packet queue: per-channel FIFOs, round-robin arbiter, registered output
module pc_queue_mc
    import pc_queue_mc_pkg::*;
#(
    parameter int PACKET_WIDTH = PC_PACKET_WIDTH,
    parameter int DEPTH        = 16,
    parameter int NUM_CH       = 2,
    localparam int CNT_W       = $clog2(DEPTH) + 1,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           FLUSH,
    input  logic [NUM_CH-1:0]              RECEIVE_PC_VALID,
    input  logic [NUM_CH*PACKET_WIDTH-1:0] RECEIVE_PC_DATA,
    output logic [NUM_CH-1:0]              RECEIVE_PC_READY,
    output logic                           SEND_PC_VALID,
    output logic [PACKET_WIDTH-1:0]        SEND_PC_DATA,
    output logic [CH_W-1:0]                SEND_PC_CH,
    input  logic                           SEND_PC_READY,
    output logic [NUM_CH*CNT_W-1:0]        FILL_COUNT
);

    logic [NUM_CH-1:0]       full;
    logic [NUM_CH-1:0]       empty;
    logic [NUM_CH-1:0]       rd_en;
    logic [CNT_W-1:0]        count [NUM_CH];
    logic [PACKET_WIDTH-1:0] head  [NUM_CH];

    logic                    send_valid_q, send_valid_d;
    logic [PACKET_WIDTH-1:0] send_data_q,  send_data_d;
    logic [CH_W-1:0]         send_ch_q,    send_ch_d;
    logic [CH_W-1:0]         last_q,       last_d;

    logic                    grant_valid;
    logic [CH_W-1:0]         grant_ch;
    logic [CH_W:0]           cand;
    logic                    load;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pc_fifo #(
            .PACKET_WIDTH (PACKET_WIDTH),
            .DEPTH        (DEPTH)
        ) u_fifo (
            .clk     (CLK),
            .rst     (RST),
            .flush   (FLUSH),
            .wr_en   (RECEIVE_PC_VALID[g]),
            .wr_data (RECEIVE_PC_DATA[g*PACKET_WIDTH +: PACKET_WIDTH]),
            .rd_en   (rd_en[g]),
            .full    (full[g]),
            .empty   (empty[g]),
            .count   (count[g]),
            .head    (head[g])
        );

        assign rd_en[g]                      = load && (grant_ch == CH_W'(g));
        assign FILL_COUNT[g*CNT_W +: CNT_W]  = count[g];
    end

    assign RECEIVE_PC_READY = ~full;

    // Search starts just after the last granted channel and wraps, so every channel is visited once.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = last_q;
        cand        = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = {1'b0, last_q} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            if (!grant_valid && !empty[cand[CH_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_ch    = cand[CH_W-1:0];
            end
        end
    end

    assign load = !FLUSH && grant_valid && (!send_valid_q || SEND_PC_READY);

    always_comb begin
        send_valid_d = send_valid_q;
        send_data_d  = send_data_q;
        send_ch_d    = send_ch_q;
        last_d       = last_q;
        if (FLUSH) begin
            send_valid_d = 1'b0;
            last_d       = CH_W'(NUM_CH - 1);
        end else if (load) begin
            send_valid_d = 1'b1;
            send_data_d  = head[grant_ch];
            send_ch_d    = grant_ch;
            last_d       = grant_ch;
        end else if (send_valid_q && SEND_PC_READY) begin
            send_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            send_valid_q <= 1'b0;
            send_data_q  <= '0;
            send_ch_q    <= '0;
            last_q       <= CH_W'(NUM_CH - 1);
        end else begin
            send_valid_q <= send_valid_d;
            send_data_q  <= send_data_d;
            send_ch_q    <= send_ch_d;
            last_q       <= last_d;
        end
    end

    assign SEND_PC_VALID = send_valid_q;
    assign SEND_PC_DATA  = send_data_q;
    assign SEND_PC_CH    = send_ch_q;

endmodule

// File: tb/tb_pc_queue_mc.sv
// tb/tb_pc_queue_mc.sv - scoreboard bench for the multi-channel packet queue
module tb_pc_queue_mc;

    localparam int PW    = 175;
    localparam int DEPTH = 16;
    localparam int NCH   = 2;
    localparam int CNT_W = 5;
    localparam int CH_W  = 1;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 FLUSH = 1'b0;
    logic [NCH-1:0]       rx_valid = '0;
    logic [NCH*PW-1:0]    rx_data = '0;
    logic [NCH-1:0]       rx_ready;
    logic                 tx_valid;
    logic [PW-1:0]        tx_data;
    logic [CH_W-1:0]      tx_ch;
    logic                 tx_ready = 1'b0;
    logic [NCH*CNT_W-1:0] fill;

    pc_queue_mc #(
        .PACKET_WIDTH (PW),
        .DEPTH        (DEPTH),
        .NUM_CH       (NCH)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .FLUSH            (FLUSH),
        .RECEIVE_PC_VALID (rx_valid),
        .RECEIVE_PC_DATA  (rx_data),
        .RECEIVE_PC_READY (rx_ready),
        .SEND_PC_VALID    (tx_valid),
        .SEND_PC_DATA     (tx_data),
        .SEND_PC_CH       (tx_ch),
        .SEND_PC_READY    (tx_ready),
        .FILL_COUNT       (fill)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [PW-1:0] exp_q0 [$];
    logic [PW-1:0] exp_q1 [$];
    int            ch_log [$];
    int            stamp_log [$];
    int            cyc = 0;
    logic          stall_prev = 1'b0;
    logic [PW-1:0] data_prev = '0;
    logic [CH_W-1:0] ch_prev = '0;

    always @(posedge RST) begin
        exp_q0.delete();
        exp_q1.delete();
        stall_prev = 1'b0;
    end

    // Inputs change just after the rising edge, so the falling edge sees what the next edge will transfer.
    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            if (stall_prev && tx_valid) begin
                check_eq("hold_data", tx_data, data_prev);
                check_eq("hold_ch", tx_ch, ch_prev);
            end
            if (tx_valid && tx_ready && !FLUSH) begin
                ch_log.push_back(int'(tx_ch));
                stamp_log.push_back(cyc);
                if (tx_ch == 1'b0) begin
                    check_eq("sb_has_entry_ch0", exp_q0.size() > 0, 1'b1);
                    if (exp_q0.size() > 0) check_eq("sb_data_ch0", tx_data, exp_q0.pop_front());
                end else begin
                    check_eq("sb_has_entry_ch1", exp_q1.size() > 0, 1'b1);
                    if (exp_q1.size() > 0) check_eq("sb_data_ch1", tx_data, exp_q1.pop_front());
                end
            end
            if (FLUSH) begin
                exp_q0.delete();
                exp_q1.delete();
            end else begin
                if (rx_valid[0] && rx_ready[0]) exp_q0.push_back(rx_data[0 +: PW]);
                if (rx_valid[1] && rx_ready[1]) exp_q1.push_back(rx_data[PW +: PW]);
            end
            stall_prev = tx_valid && !tx_ready && !FLUSH;
            data_prev  = tx_data;
            ch_prev    = tx_ch;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [PW-1:0] rnd_pkt();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[PW-1:0];
    endfunction

    task automatic set_rx(input int ch, input logic [PW-1:0] d);
        rx_valid[ch]        = 1'b1;
        rx_data[ch*PW +: PW] = d;
    endtask

    task automatic drain(input int bound, input bit toggle);
        int n;
        n = 0;
        rx_valid = '0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || tx_valid) && n < bound) begin
            tx_ready = toggle ? ~tx_ready : 1'b1;
            step();
            n++;
        end
        check_eq("drain_in_time", n < bound, 1'b1);
        check_eq("drain_fill", fill, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] first;
        logic [PW-1:0] a5;

        #12;
        check_eq("rst_valid", tx_valid, 1'b0);
        check_eq("rst_data", tx_data, '0);
        check_eq("rst_ch", tx_ch, '0);
        check_eq("rst_fill", fill, '0);
        check_eq("rst_ready", rx_ready, 2'b11);
        step();

        // Single packet latency
        RST = 1'b0;
        tx_ready = 1'b1;
        a5 = '0;
        a5[7:0] = 8'hA5;
        set_rx(0, a5);
        step();
        rx_valid = '0;
        check_eq("lat_not_yet", tx_valid, 1'b0);
        step();
        check_eq("lat_valid", tx_valid, 1'b1);
        check_eq("lat_data", tx_data, 256'hA5);
        check_eq("lat_ch", tx_ch, 1'b0);
        step();
        check_eq("lat_empty_after", tx_valid, 1'b0);

        // Fill channel 1 to full with output stalled
        tx_ready = 1'b0;
        first = rnd_pkt();
        for (int i = 0; i < 17; i++) begin
            set_rx(1, (i == 0) ? first : rnd_pkt());
            step();
        end
        check_eq("full_count_ch1", fill[CNT_W +: CNT_W], 16);
        check_eq("full_ready_ch1", rx_ready[1], 1'b0);
        check_eq("full_ready_ch0", rx_ready[0], 1'b1);
        check_eq("full_out_valid", tx_valid, 1'b1);
        check_eq("full_out_data", tx_data, first);
        check_eq("full_out_ch", tx_ch, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_rx(1, rnd_pkt());
            step();
        end
        check_eq("full_count_hold", fill[CNT_W +: CNT_W], 16);
        drain(100, 1'b0);

        // Round-robin across two preloaded channels
        tx_ready = 1'b0;
        ch_log.delete();
        stamp_log.delete();
        for (int i = 0; i < 3; i++) begin
            set_rx(0, rnd_pkt());
            set_rx(1, rnd_pkt());
            step();
        end
        drain(50, 1'b0);
        check_eq("rr_count", ch_log.size(), 6);
        for (int i = 0; i < 6 && i < ch_log.size(); i++) begin
            check_eq("rr_ch_seq", ch_log[i], i % 2);
            check_eq("rr_back_to_back", stamp_log[i] - stamp_log[0], i);
        end

        // Streaming with downstream stalls
        for (int i = 0; i < 8; i++) begin
            set_rx(0, rnd_pkt());
            tx_ready = (i % 2 == 0);
            step();
        end
        drain(100, 1'b1);

        // Flush with stored packets and a concurrent write
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_rx(0, rnd_pkt());
            step();
        end
        rx_valid = '0;
        check_eq("pre_flush_count", fill[0 +: CNT_W], 5);
        check_eq("pre_flush_valid", tx_valid, 1'b1);
        FLUSH = 1'b1;
        set_rx(0, rnd_pkt());
        set_rx(1, rnd_pkt());
        step();
        FLUSH = 1'b0;
        rx_valid = '0;
        check_eq("flush_fill", fill, '0);
        check_eq("flush_valid", tx_valid, 1'b0);
        check_eq("flush_ready", rx_ready, 2'b11);
        step();
        check_eq("flush_write_dropped", fill, '0);
        check_eq("flush_valid_stays", tx_valid, 1'b0);
        ch_log.delete();
        set_rx(0, rnd_pkt());
        set_rx(1, rnd_pkt());
        step();
        drain(50, 1'b0);
        check_eq("flush_arb_count", ch_log.size(), 2);
        if (ch_log.size() > 0) check_eq("flush_arb_first_ch0", ch_log[0], 0);

        // Asynchronous reset between edges
        tx_ready = 1'b0;
        set_rx(0, rnd_pkt());
        step();
        rx_valid = '0;
        step();
        check_eq("prerst_valid", tx_valid, 1'b1);
        #1;
        RST = 1'b1;
        #1;
        check_eq("arst_valid", tx_valid, 1'b0);
        check_eq("arst_data", tx_data, '0);
        check_eq("arst_ch", tx_ch, '0);
        check_eq("arst_fill", fill, '0);
        check_eq("arst_ready", rx_ready, 2'b11);
        RST = 1'b0;
        set_rx(0, rnd_pkt());
        step();
        rx_valid = '0;
        check_eq("post_rst_accept", fill[0 +: CNT_W], 1);
        check_eq("post_rst_valid", tx_valid, 1'b0);
        drain(20, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
